// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide engine and the ID-stage decoder.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_DONE = 2'b10
  } md_state_e;

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_mul(input md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Operand/result bundle between the ID/EX pipeline register and muldiv_unit.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             Start_i;
  logic [1:0]       Op_i;
  logic [WIDTH-1:0] Data1_i;
  logic [WIDTH-1:0] Data2_i;
  logic             Busy_o;
  logic             Done_o;
  logic             DivByZero_o;
  logic [WIDTH-1:0] Hi_o;
  logic [WIDTH-1:0] Lo_o;

  modport master (
    output Start_i, Op_i, Data1_i, Data2_i,
    input  Busy_o, Done_o, DivByZero_o, Hi_o, Lo_o
  );

  modport slave (
    input  Start_i, Op_i, Data1_i, Data2_i,
    output Busy_o, Done_o, DivByZero_o, Hi_o, Lo_o
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: magnitude on the way in, sign restore on the way out.
module muldiv_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);
  assign result = negate ? ({W{1'b0}} - value) : value;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO.
// MULDIV_FAST_MUL_EN: multiplies complete in one edge instead of WIDTH iterations.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic     Clock_i,
  input logic     Reset_i,
  muldiv_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  md_state_e          state_r;
  md_op_e             op_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [WIDTH-1:0]   operand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic               neg_q_r, neg_r_r, dz_r;
  logic               busy_r, done_r, dbz_r;
  logic [WIDTH-1:0]   hi_r, lo_r;

  md_op_e             op_s;
  logic               sign_a_s, sign_b_s, accept_s, fast_mul_s, fix_neg_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, rem_diff_s;
  logic [WIDTH:0]     mul_sum_s, rem_shift_s;
  logic [2*WIDTH-1:0] acc_next_s, fix_in_s, prod_fix_s;
  logic [WIDTH-1:0]   quo_fix_s, rem_fix_s, res_hi_s, res_lo_s;

  assign op_s     = md_op_e'(bus.Op_i);
  assign sign_a_s = md_is_signed(op_s) & bus.Data1_i[WIDTH-1];
  assign sign_b_s = md_is_signed(op_s) & bus.Data2_i[WIDTH-1];
  assign accept_s = bus.Start_i && (state_r != MD_CALC);

`ifdef MULDIV_FAST_MUL_EN
  assign fast_mul_s = md_is_mul(op_s);
`else
  assign fast_mul_s = 1'b0;
`endif

  muldiv_signfix #(.W(WIDTH))   u_abs_a (.value(bus.Data1_i), .negate(sign_a_s), .result(mag_a_s));
  muldiv_signfix #(.W(WIDTH))   u_abs_b (.value(bus.Data2_i), .negate(sign_b_s), .result(mag_b_s));
  muldiv_signfix #(.W(2*WIDTH)) u_fix_p (.value(fix_in_s), .negate(fix_neg_s), .result(prod_fix_s));
  muldiv_signfix #(.W(WIDTH))   u_fix_q (.value(acc_next_s[WIDTH-1:0]), .negate(neg_q_r), .result(quo_fix_s));
  muldiv_signfix #(.W(WIDTH))   u_fix_r (.value(acc_next_s[2*WIDTH-1:WIDTH]), .negate(neg_r_r), .result(rem_fix_s));

  // acc_r is {HI-side, LO-side}: multiplier/quotient bits live in the low half.
  assign mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, operand_r};
  assign rem_shift_s = acc_r[2*WIDTH-1:WIDTH-1];
  assign rem_diff_s  = rem_shift_s[WIDTH-1:0] - operand_r;

  // One shift-add or restoring shift-subtract step.
  always_comb begin
    acc_next_s = acc_r;
    if (md_is_mul(op_r)) begin
      if (acc_r[0]) begin
        acc_next_s = {mul_sum_s, acc_r[WIDTH-1:1]};
      end else begin
        acc_next_s = {1'b0, acc_r[2*WIDTH-1:1]};
      end
    end else if (rem_shift_s >= {1'b0, operand_r}) begin
      acc_next_s = {rem_diff_s, acc_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_next_s = {rem_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
    end
  end

  // Product sign-fix input: single-cycle product at accept, else the final iteration.
  always_comb begin
    fix_in_s  = acc_next_s;
    fix_neg_s = neg_q_r;
    if (fast_mul_s && accept_s) begin
      fix_in_s  = {{WIDTH{1'b0}}, mag_a_s} * {{WIDTH{1'b0}}, mag_b_s};
      fix_neg_s = sign_a_s ^ sign_b_s;
    end else begin
      fix_in_s  = acc_next_s;
      fix_neg_s = neg_q_r;
    end
  end

  // Final HI/LO selection; divide-by-zero forces an all-ones quotient.
  always_comb begin
    res_hi_s = rem_fix_s;
    res_lo_s = quo_fix_s;
    if (md_is_mul(op_r)) begin
      {res_hi_s, res_lo_s} = prod_fix_s;
    end else if (dz_r) begin
      res_hi_s = rem_fix_s;
      res_lo_s = {WIDTH{1'b1}};
    end else begin
      res_hi_s = rem_fix_s;
      res_lo_s = quo_fix_s;
    end
  end

  // Control FSM with registered status and HI/LO.
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_r   <= MD_IDLE;
      op_r      <= MD_MULT;
      cnt_r     <= {CNT_W{1'b0}};
      operand_r <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      dz_r      <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dbz_r     <= 1'b0;
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        MD_IDLE, MD_DONE: begin
          if (bus.Start_i) begin
            op_r      <= op_s;
            operand_r <= mag_b_s;
            acc_r     <= {{WIDTH{1'b0}}, mag_a_s};
            neg_q_r   <= sign_a_s ^ sign_b_s;
            neg_r_r   <= sign_a_s;
            dz_r      <= !md_is_mul(op_s) && (bus.Data2_i == {WIDTH{1'b0}});
            cnt_r     <= {CNT_W{1'b0}};
            dbz_r     <= 1'b0;
            if (fast_mul_s) begin
              {hi_r, lo_r} <= prod_fix_s;
              state_r      <= MD_DONE;
              busy_r       <= 1'b0;
              done_r       <= 1'b1;
            end else begin
              state_r <= MD_CALC;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= MD_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        MD_CALC: begin
          acc_r <= acc_next_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_CNT) begin
            hi_r    <= res_hi_s;
            lo_r    <= res_lo_s;
            dbz_r   <= dz_r;
            state_r <= MD_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= MD_CALC;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= MD_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy_o      = busy_r;
  assign bus.Done_o      = done_r;
  assign bus.DivByZero_o = dbz_r;
  assign bus.Hi_o        = hi_r;
  assign bus.Lo_o        = lo_r;

endmodule
